// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default operand width for the restoring divider.
package div_pkg;
    localparam int DIV_WIDTH = 8;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_TRIAL, S_FIX, S_DONE} div_state_t;
endpackage

// File: rtl/div_control.sv
// div_control: divider FSM and bit counter; emits per-state strobes plus Busy/Done.
// With DIV_SIGNED_EN a FIX state follows the final trial.
module div_control
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic zero_i,
    output logic load_o,
    output logic shift_o,
    output logic trial_o,
    output logic fin_o,
    output logic busy_o,
    output logic done_o
);
    localparam int CW = $clog2(WIDTH);

    div_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  state_d = run_i ? S_LOAD : S_IDLE;
            S_LOAD: begin
                cnt_d   = '0;
                state_d = zero_i ? S_DONE : S_SHIFT;
            end
            S_SHIFT: state_d = S_TRIAL;
            S_TRIAL: begin
                cnt_d = cnt_q + CW'(1);
`ifdef DIV_SIGNED_EN
                state_d = last ? S_FIX : S_SHIFT;
`else
                state_d = last ? S_DONE : S_SHIFT;
`endif
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = run_i ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign load_o  = state_q == S_LOAD;
    assign shift_o = state_q == S_SHIFT;
    assign trial_o = state_q == S_TRIAL;
    // fin_o marks the cycle whose closing edge enters DONE with a computed result
`ifdef DIV_SIGNED_EN
    assign fin_o   = state_q == S_FIX;
`else
    assign fin_o   = trial_o && last;
`endif
    assign busy_o  = load_o || shift_o || trial_o || state_q == S_FIX;
    assign done_o  = state_q == S_DONE;
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential restoring divider, one shift/trial-subtract pair per quotient bit.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             Div0
);
    logic load, shift, trial, fin, div_zero;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d, a_mag, b_mag;
    logic div0_q, div0_d;
    logic [WIDTH:0] diff;
`ifdef DIV_SIGNED_EN
    logic neg_q, neg_d, flip_q, flip_d;
    assign a_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
    assign b_mag = Divisor[WIDTH-1] ? -Divisor : Divisor;
`else
    assign a_mag = Dividend;
    assign b_mag = Divisor;
`endif

    assign div_zero = Divisor == '0;
    assign diff     = {1'b0, r_q} - {1'b0, d_q};

    div_control #(.WIDTH(WIDTH)) u_ctrl (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .run_i  (Run),
        .zero_i (div_zero),
        .load_o (load),
        .shift_o(shift),
        .trial_o(trial),
        .fin_o  (fin),
        .busy_o (Busy),
        .done_o (Done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            div0_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q  <= 1'b0;
            flip_q <= 1'b0;
`endif
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            d_q    <= d_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div0_q <= div0_d;
`ifdef DIV_SIGNED_EN
            neg_q  <= neg_d;
            flip_q <= flip_d;
`endif
        end
    end

    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        div0_d = div0_q;
`ifdef DIV_SIGNED_EN
        neg_d  = neg_q;
        flip_d = flip_q;
`endif
        if (load) begin
            r_d    = '0;
            q_d    = a_mag;
            d_d    = b_mag;
            div0_d = div_zero;
`ifdef DIV_SIGNED_EN
            neg_d  = Dividend[WIDTH-1];
            flip_d = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
`endif
            // divide-by-zero skips the loop and reports the raw dividend
            if (div_zero) begin
                quo_d = '1;
                rem_d = Dividend;
            end
        end
        if (shift) {r_d, q_d} = {r_q, q_q} << 1;
        if (trial) begin
            r_d = diff[WIDTH] ? r_q : diff[WIDTH-1:0];
            q_d = {q_q[WIDTH-1:1], ~diff[WIDTH]};
        end
        if (fin) begin
`ifdef DIV_SIGNED_EN
            quo_d = flip_q ? -q_q : q_q;
            rem_d = neg_q ? -r_q : r_q;
`else
            quo_d = q_d;
            rem_d = r_d;
`endif
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rem_q;
    assign Div0      = div0_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed vectors against a transaction-level arithmetic model.
// Builds for both unsigned and DIV_SIGNED_EN configurations.
module tb_restoring_divider;
    localparam int W = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = 2 * W + 3;
`else
    localparam int LAT = 2 * W + 2;
`endif

    logic clk = 1'b0;
    logic Reset = 1'b1, Run = 1'b0;
    logic [W-1:0] Dividend = '0, Divisor = '0;
    logic [W-1:0] Quotient, Remainder;
    logic Busy, Done, Div0;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    restoring_divider dut (
        .Clk(clk), .Reset(Reset), .Run(Run), .Dividend(Dividend), .Divisor(Divisor),
        .Quotient(Quotient), .Remainder(Remainder), .Busy(Busy), .Done(Done), .Div0(Div0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] q_ref(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_SIGNED_EN
        int sa = $signed(a);
        int sb = $signed(b);
        return W'(sa / sb);
`else
        return a / b;
`endif
    endfunction

    function automatic logic [W-1:0] r_ref(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_SIGNED_EN
        int sa = $signed(a);
        int sb = $signed(b);
        return W'(sa % sb);
`else
        return a % b;
`endif
    endfunction

    // model: 0 idle, 1 busy (m_t = cycles since Run was accepted), 2 done
    int m_mode = 0;
    int m_t = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
    logic m_div0 = 1'b0;

    always @(posedge clk) begin
        if (Reset) begin
            m_mode <= 0;
            m_q    <= '0;
            m_r    <= '0;
            m_div0 <= 1'b0;
        end else if (m_mode == 0) begin
            if (Run) begin
                m_mode <= 1;
                m_t    <= 1;
            end
        end else if (m_mode == 1) begin
            m_t <= m_t + 1;
            if (m_t == 1) begin
                m_a    <= Dividend;
                m_b    <= Divisor;
                m_div0 <= Divisor == '0;
                if (Divisor == '0) begin
                    m_mode <= 2;
                    m_q    <= '1;
                    m_r    <= Dividend;
                end
            end else if (m_t + 1 == LAT) begin
                m_mode <= 2;
                m_q    <= q_ref(m_a, m_b);
                m_r    <= r_ref(m_a, m_b);
            end
        end else if (!Run) begin
            m_mode <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", Busy, m_mode == 1);
            check("model_done", Done, m_mode == 2);
            check("model_quotient", Quotient, m_q);
            check("model_remainder", Remainder, m_r);
            check("model_div0", Div0, m_div0);
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic ed0, input int elat, input bit drop);
        int n = 0;
        Dividend = a;
        Divisor  = b;
        Run      = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!Done && n < 100);
        check("done_cycle", n, elat);
        check("quotient", Quotient, eq);
        check("remainder", Remainder, er);
        check("div0", Div0, ed0);
        if (drop) begin
            Run = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_quotient", Quotient, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Reset  = 1'b0;
        chk_en = 1'b1;
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, 1'b1);
`ifdef DIV_SIGNED_EN
        run_op(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, LAT, 1'b1);
        run_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT, 1'b1);
        run_op(8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, LAT, 1'b1);
`else
        run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT, 1'b1);
        run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, LAT, 1'b1);
        run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT, 1'b1);
`endif
        run_op(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 2, 1'b1);
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, 1'b1);
        // reset in the middle of an operation discards it
        Dividend = 8'd100;
        Divisor  = 8'd7;
        Run      = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_busy", Busy, 1);
        Reset = 1'b1;
        Run   = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_quotient", Quotient, 0);
        check("mid_rst_remainder", Remainder, 0);
        check("mid_rst_done", Done, 0);
        Reset = 1'b0;
        @(negedge clk);
        // Run held through DONE must not restart even with a new dividend
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, 1'b0);
        Dividend = 8'd120;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_done", Done, 1);
            check("hold_quotient", Quotient, 14);
        end
        Run = 1'b0;
        @(negedge clk);
        check("restart_idle", Done, 0);
        run_op(8'd120, 8'd7, 8'd17, 8'd1, 1'b0, LAT, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential restoring divider, the inverse companion to the lab's add/shift multiplier: it divides an unsigned WIDTH-bit dividend by a WIDTH-bit divisor using one shift/trial-subtract pair per quotient bit. It sits beside the multiplier in the arithmetic lab top level, uses the same switch-loaded operands and Run-level handshake, and drives hex displays with Quotient/Remainder.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- Clk  input  1  system clock, all state changes on rising edge
- Reset  input  1  synchronous, active-high reset
- Run  input  1  level start; sampled in IDLE, must drop before the next operation
- Dividend  input  WIDTH  numerator, sampled only in LOAD
- Divisor  input  WIDTH  denominator, sampled only in LOAD
- Quotient  output  WIDTH  registered result, updated only on entry to DONE
- Remainder  output  WIDTH  registered result, updated only on entry to DONE
- Busy  output  1  high in LOAD, SHIFT, TRIAL (and FIX when enabled)
- Done  output  1  high only in DONE
- Div0  output  1  registered; set on entry to DONE when Divisor was 0, cleared on next LOAD

## Operation
- States: IDLE, LOAD, SHIFT, TRIAL, (FIX), DONE.
- IDLE: Run=1 → LOAD; else stay.
- LOAD: R←0, Q←Dividend, D←Divisor, cnt←0, Div0←0. D==0 → DONE with Quotient←all ones, Remainder←Dividend, Div0←1. Else → SHIFT.
- SHIFT: {R,Q} ← {R,Q}<<1 → TRIAL.
- TRIAL: diff = {1'b0,R} − {1'b0,D} (WIDTH+1 bits). diff[WIDTH]==0 → R←diff[WIDTH-1:0], Q[0]←1; else R unchanged, Q[0]←0. cnt←cnt+1. cnt==WIDTH−1 (last bit) → DONE (or FIX); else → SHIFT.
- DONE: Quotient←Q, Remainder←R on entry; hold while Run=1; Run=0 → IDLE.
- Counter width $clog2(WIDTH); no wrap used beyond WIDTH−1.
- Operand changes after LOAD ignored. Run toggling during Busy ignored.
- Reset at any time: state IDLE, Quotient=0, Remainder=0, Busy=0, Done=0, Div0=0, internal R/Q/D/cnt=0; in-flight result discarded.

## Timing
- Run sampled high in IDLE at cycle 0 → LOAD cycle 1 → 2·WIDTH SHIFT/TRIAL cycles → Done first high cycle 2·WIDTH+2 (18 for WIDTH=8).
- Divide-by-zero: Done first high cycle 2.
- Run held high through DONE: no restart. Minimum restart: Run low ≥1 cycle in DONE → IDLE next cycle → Run high sampled the following cycle.
- Outputs registered; no combinational path from inputs to outputs.

## Configuration
- DIV_SIGNED_EN defined: operands are two's complement. LOAD stores magnitudes and both signs; FIX state inserted after final TRIAL: Quotient negated if signs differ, Remainder takes Dividend sign. Latency 2·WIDTH+3. −2^(WIDTH−1)/−1 yields Quotient=0x80 (WIDTH=8), Remainder=0, no flag. Div0 behaviour unchanged (Remainder = raw Dividend).
- Undefined: unsigned only, no FIX state, latency as above.

## Structure
- Package div_pkg: state enum typedef (div_state_t), default WIDTH constant.
- Sub-module div_control: FSM plus bit counter, outputs load/shift/trial/fix/done strobes and Busy/Done; restoring_divider holds R/Q/D, subtractor and result registers.

## Test plan
- 100/7, Run held → Busy cycles 1–17, Done at cycle 18, Quotient=14, Remainder=2, Div0=0.
- 255/1 → 255 rem 0; 5/9 → 0 rem 5; 255/255 → 1 rem 0.
- 37/0 → Done at cycle 2, Quotient=0xFF, Remainder=37, Div0=1; next 100/7 clears Div0.
- Reset asserted at cycle 8 of 100/7 → next cycle IDLE, all outputs 0; fresh 100/7 yields 14 rem 2.
- Run held high 10 cycles in DONE, Dividend changed → no restart, outputs stable; Run low then high → new result.
- DIV_SIGNED_EN: −100/7 → Quotient=0xF2 (−14), Remainder=0xFE (−2), Done at cycle 19; −128/−1 → 0x80 rem 0.
